// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, x/y raster counters, and registered
// sync / active-video / line-start / frame-start strobes aligned with o_x/o_y.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  output logic       o_pix_en,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic       o_line_start,
  output logic       o_frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Next-state: divider, raster advance on the registered strobe, and strobe
  // decode from the next coordinates so strobes line up with o_x/o_y.
  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_d      = (div_d == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    hsync_d  = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vsync_d  = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    active_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      active_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_pix_en      = pix_en_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_active      = active_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (small raster with
// CLK_DIV=1, small raster with CLK_DIV=3 and active-high sync, default VGA),
// randomized reset pulses, expectations from a pixel-index reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
  } obs_t;

  // Instance A outputs
  logic a_pe, a_hs, a_vs, a_act, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  // Instance B outputs
  logic b_pe, b_hs, b_vs, b_act, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  // Instance C outputs
  logic c_pe, c_hs, c_vs, c_act, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(1), .SYNC_POL(0)
  ) dut_a (
    .i_clock(clk), .i_reset(rst), .o_pix_en(a_pe), .o_x(a_x), .o_y(a_y),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_active(a_act),
    .o_line_start(a_ls), .o_frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(3), .SYNC_POL(1)
  ) dut_b (
    .i_clock(clk), .i_reset(rst), .o_pix_en(b_pe), .o_x(b_x), .o_y(b_y),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_active(b_act),
    .o_line_start(b_ls), .o_frame_start(b_fs)
  );

  vga_timing_gen dut_c (
    .i_clock(clk), .i_reset(rst), .o_pix_en(c_pe), .o_x(c_x), .o_y(c_y),
    .o_hsync(c_hs), .o_vsync(c_vs), .o_active(c_act),
    .o_line_start(c_ls), .o_frame_start(c_fs)
  );

  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Pixels advanced after k edges since reset: one per strobe cycle j in
  // [1, k-1] where the divider phase is CLK_DIV-1.
  function automatic int unsigned pix_count(int unsigned k, int unsigned d);
    int unsigned c;
    if (k == 0) return 0;
    c = k / d;
    if (d == 1) c = c - 1;
    return c;
  endfunction

  function automatic obs_t model(int unsigned k,
                                 int unsigned hv, int unsigned hf,
                                 int unsigned hsw, int unsigned hb,
                                 int unsigned vv, int unsigned vf,
                                 int unsigned vsw, int unsigned vb,
                                 int unsigned d, int unsigned pol);
    obs_t o;
    int unsigned ht, vt, p, x, y;
    bit adv, hs_on, vs_on;
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    p     = pix_count(k, d);
    x     = p % ht;
    y     = (p / ht) % vt;
    adv   = (k >= 1) && (p != pix_count(k - 1, d));
    hs_on = (x >= hv + hf) && (x < hv + hf + hsw);
    vs_on = (y >= vv + vf) && (y < vv + vf + vsw);
    o.pix_en = (k >= 1) && ((k % d) == d - 1);
    o.x      = 10'(x);
    o.y      = 10'(y);
    o.hs     = (hs_on == (pol != 0));
    o.vs     = (vs_on == (pol != 0));
    o.act    = (x < hv) && (y < vv);
    o.ls     = adv && (x == 0);
    o.fs     = adv && (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic obs_t pack(logic pe, logic [9:0] x, logic [9:0] y,
                                logic hs, logic vs, logic act, logic ls, logic fs);
    obs_t o;
    o.pix_en = pe; o.x = x; o.y = y; o.hs = hs; o.vs = vs;
    o.act = act; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  task automatic chk_obs(string name, obs_t got, obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got(pe=%b x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b) exp(pe=%b x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b)",
               name, cyc, got.pix_en, got.x, got.y, got.hs, got.vs, got.act, got.ls, got.fs,
               exp.pix_en, exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Stimulus: drive reset on the falling edge and push the expected
  // post-edge observation for every instance.
  initial begin
    int unsigned k, kn, hold;
    rst  = 1'b1;
    k    = 0;
    hold = 0;
    for (int i = 0; i < 8000; i++) begin
      kn = rst ? 0 : k + 1;
      qa.push_back(model(kn, 16, 2, 3, 4, 8, 2, 2, 3, 1, 0));
      qb.push_back(model(kn, 10, 3, 4, 5, 6, 1, 2, 2, 3, 1));
      qc.push_back(model(kn, 640, 16, 96, 48, 480, 10, 2, 33, 1, 0));
      k = kn;
      @(posedge clk);
      @(negedge clk);
      if (n_mis >= 40) break;
      if (i < 2) begin
        rst = 1'b1;
      end else if (i < 2200) begin
        rst = 1'b0;
      end else if (hold > 0) begin
        rst  = 1'b1;
        hold = hold - 1;
      end else if ($urandom_range(299) == 0) begin
        rst  = 1'b1;
        hold = $urandom_range(2);
      end else begin
        rst = 1'b0;
      end
    end
    for (int i = 0; i < 4 && (qa.size() + qb.size() + qc.size()) != 0; i++) @(negedge clk);
    chk_int("scoreboard_drain", qa.size() + qb.size() + qc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Monitor: pops expectations after every edge, plus frame/line aggregate
  // checks on spans that saw no reset.
  initial begin
    int a_last, a_act_n, a_corner;
    int b_last, b_act_n, b_corner;
    int c_hs_n, c_first;
    a_last = -1; a_act_n = 0; a_corner = 0;
    b_last = -1; b_act_n = 0; b_corner = 0;
    c_hs_n = 0;  c_first = -1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() != 0) chk_obs("A", pack(a_pe, a_x, a_y, a_hs, a_vs, a_act, a_ls, a_fs), qa.pop_front());
      if (qb.size() != 0) chk_obs("B", pack(b_pe, b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs), qb.pop_front());
      if (qc.size() != 0) chk_obs("C", pack(c_pe, c_x, c_y, c_hs, c_vs, c_act, c_ls, c_fs), qc.pop_front());

      if (rst) begin
        a_last = -1; b_last = -1;
        c_hs_n = 0;  c_first = -1;
      end else begin
        if (a_fs) begin
          if (a_last >= 0) begin
            chk_int("A_frame_cycles", cyc - a_last, 25 * 15);
            chk_int("A_active_cycles", a_act_n, 16 * 8);
            chk_int("A_last_pixel_seen", a_corner, 1);
          end
          a_last = cyc; a_act_n = int'(a_act); a_corner = 0;
        end else begin
          a_act_n += int'(a_act);
          if (a_x == 10'd24 && a_y == 10'd14) a_corner++;
        end
        if (b_fs) begin
          if (b_last >= 0) begin
            chk_int("B_frame_cycles", cyc - b_last, 22 * 11 * 3);
            chk_int("B_active_cycles", b_act_n, 10 * 6 * 3);
            chk_int("B_last_pixel_cycles", b_corner, 3);
          end
          b_last = cyc; b_act_n = int'(b_act); b_corner = 0;
        end else begin
          b_act_n += int'(b_act);
          if (b_x == 10'd21 && b_y == 10'd10) b_corner++;
        end
        if (c_ls) begin
          chk_int("C_hsync_width", c_hs_n, 96);
          chk_int("C_hsync_first_x", c_first, 656);
          c_hs_n = 0; c_first = -1;
        end
        if (!c_hs) begin
          c_hs_n++;
          if (c_first < 0) c_first = int'(c_x);
        end
      end
    end
  end

endmodule
